div_dp_round: RTL and testbench
===============================

Name: div_dp_round

Overview:
- Post-divide normalize/round/pack stage. It sits directly downstream of the double-precision restoring/non-restoring mantissa divider.
- It consumes the raw quotient word, the unbiased exponent difference, the sign, the remainder-sticky flag and the special-case class. It produces a packed IEEE-754 binary64 result.
- Rounding is round-to-nearest-even. There is no subnormal output: underflow flushes to signed zero.
- It is a 3-stage valid/ready pipeline with a global stall.

Parameters:
- EXP_W, 13, width of signed unbiased exponent input (two's complement).
- Q_W, 56, quotient width. Binary point sits after bit Q_W-1, so value = in_quot / 2^(Q_W-1), legal range [0.5, 2).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  stage can accept input.
- in_sign  in  1  result sign (a_sign ^ b_sign).
- in_exp  in  EXP_W  signed unbiased exponent (exp_a - exp_b).
- in_quot  in  Q_W  raw quotient; bit Q_W-1 or Q_W-2 is set for class normal.
- in_sticky  in  1  nonzero final remainder.
- in_class  in  2  00 normal, 01 zero, 10 infinity, 11 NaN.
- out_valid  out  1  o_z valid.
- out_ready  in  1  downstream accepts o_z.
- o_z  out  64  packed binary64 result.

Behaviour:
- Reset (asynchronous, any cycle, including mid-operation):
  - all stage valid bits clear and all data registers clear.
  - out_valid=0, o_z=0.
  - in_ready=1 from the first clock after reset deasserts.
  - In-flight items are discarded.
- Stall: stall = out_valid & ~out_ready. in_ready = ~stall.
  - While stall is high, no stage register changes.
  - Otherwise all stages advance every cycle. Bubbles propagate as valid=0.
- Transfer: input is captured when in_valid & in_ready. Output is consumed when out_valid & out_ready.
- Latency: exactly 3 cycles from capture to out_valid when there is no stall. Throughput is 1 per cycle. Order is preserved.
- Stage 1, normalize:
  - if in_quot[Q_W-1]=0: N = in_quot<<1, e = in_exp-1.
  - else: N = in_quot, e = in_exp.
  - Sign-extend e to EXP_W+1 bits.
  - Split N: mant = N[54:3], G = N[2], R = N[1], S = N[0] | in_sticky.
- Stage 2, round (RNE):
  - inc = G & (R | S | mant[0]).
  - m53 = {1'b0, mant} + inc.
  - If m53[52]=1 (carry out): mant = 0, e = e+1.
- Stage 3, pack: E = e + 1023, computed in EXP_W+1 signed bits.
  - class normal, E >= 2047: o_z = {sign, 11'h7FF, 52'h0} (overflow to infinity).
  - class normal, E <= 0: o_z = {sign, 63'h0} (flush to zero).
  - class normal, otherwise: {sign, E[10:0], mant}.
  - class zero: {sign, 63'h0}.
  - class infinity: {sign, 11'h7FF, 52'h0}.
  - class NaN: 64'h7FF8_0000_0000_0000 (canonical quiet NaN, sign forced 0).
- Class and sign travel with the data through all stages. in_quot/in_exp/in_sticky are don't-care for non-normal classes.
- For class normal, in_quot[Q_W-1:Q_W-2]==00 is illegal. Required output in that case: treat as normal after a single shift; the result is undefined but must not hang the pipeline.
- o_z is held stable while out_valid & ~out_ready.
- When out_valid=0, o_z holds its last value.
- Simultaneous capture and consume under a full pipeline is legal; no bubble is inserted.

Test Plan:
- 1.0/1.0: sign0, exp 0, quot=1<<55, sticky0, class normal -> o_z=64'h3FF0_0000_0000_0000, out_valid exactly 3 cycles after capture.
- 1.0/1.5: exp 0, quot=56'h55_5555_5555_5555 (0.1010..b), sticky1 -> 64'h3FE5_5555_5555_5555 (truncate, G=0).
- Round carry: exp 0, quot=all ones, sticky1 -> 64'h4000_0000_0000_0000. A tie case with mant[0]=0, G=1, R=S=0 must round down.
- Range: exp +1024, quot=1<<55 -> 64'h7FF0_0000_0000_0000. Sign1, exp -1023 -> 64'h8000_0000_0000_0000. Class NaN with sign1 -> 64'h7FF8_0000_0000_0000. Class infinity with sign1 -> 64'hFFF0_0000_0000_0000.
- Backpressure: stream 6 back-to-back values while out_ready is held low for 5 cycles after the first out_valid. Required: in_ready drops while stalled, no loss or duplication, output order matches input, o_z stable during stall.
- Reset mid-flight: 2 items in pipe, pulse reset asynchronously between clock edges. Required: out_valid=0 and o_z=0 immediately, no stale item emerges afterward.

Source files
------------

// File: rtl/div_dp_round.sv
// div_dp_round: normalize, RNE round and binary64 pack after the divider.
// Three-stage valid/ready pipeline sharing one global stall.
module div_dp_round #(
  parameter int EXP_W = 13,
  parameter int Q_W   = 56
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [Q_W-1:0]   in_quot,
  input  logic             in_sticky,
  input  logic [1:0]       in_class,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      o_z
);

  localparam int EW = EXP_W + 1;
  localparam logic [EW-1:0] BIAS = EW'(1023);
  localparam logic [EW-1:0] EMAX = EW'(2047);
  localparam logic [EW-1:0] EZERO = '0;

  localparam logic [1:0] C_NORM = 2'b00;
  localparam logic [1:0] C_ZERO = 2'b01;
  localparam logic [1:0] C_INF  = 2'b10;
  localparam logic [1:0] C_NAN  = 2'b11;

  logic stall;
  logic adv;

  // stage 1 state
  logic          v1_q;
  logic          sign1_q;
  logic [1:0]    cls1_q;
  logic [EW-1:0] e1_q;
  logic [51:0]   mant1_q;
  logic          g1_q, r1_q, s1_q;

  // stage 2 state
  logic          v2_q;
  logic          sign2_q;
  logic [1:0]    cls2_q;
  logic [EW-1:0] e2_q;
  logic [51:0]   mant2_q;

  // stage 3 state
  logic          v3_q;
  logic [63:0]   z_q;

  // next-state values
  logic [Q_W-1:0] n_d;
  logic [EW-1:0]  e1_d;
  logic [EW-1:0]  e2_d;
  logic [51:0]    mant2_d;
  logic           inc;
  logic [52:0]    m53;
  logic [EW-1:0]  ebias;
  logic [63:0]    z_d;

  assign stall     = v3_q & ~out_ready;
  assign adv       = ~stall;
  assign in_ready  = ~stall;
  assign out_valid = v3_q;
  assign o_z       = z_q;

  // normalize: make the leading one sit at bit Q_W-1
  always_comb begin
    n_d  = in_quot;
    e1_d = {in_exp[EXP_W-1], in_exp};
    if (!in_quot[Q_W-1]) begin
      n_d  = in_quot << 1;
      e1_d = {in_exp[EXP_W-1], in_exp} - EW'(1);
    end
  end

  // round to nearest even; mantissa carry bumps the exponent
  always_comb begin
    inc     = g1_q & (r1_q | s1_q | mant1_q[0]);
    m53     = {1'b0, mant1_q} + 53'(inc);
    mant2_d = m53[51:0];
    e2_d    = e1_q;
    if (m53[52]) begin
      mant2_d = '0;
      e2_d    = e1_q + EW'(1);
    end
  end

  // pack into binary64 with overflow to inf and flush to zero
  always_comb begin
    ebias = e2_q + BIAS;
    z_d   = {sign2_q, 63'h0};
    unique case (cls2_q)
      C_NORM: begin
        if ($signed(ebias) >= $signed(EMAX))
          z_d = {sign2_q, 11'h7FF, 52'h0};
        else if ($signed(ebias) <= $signed(EZERO))
          z_d = {sign2_q, 63'h0};
        else
          z_d = {sign2_q, ebias[10:0], mant2_q};
      end
      C_ZERO: z_d = {sign2_q, 63'h0};
      C_INF:  z_d = {sign2_q, 11'h7FF, 52'h0};
      C_NAN:  z_d = 64'h7FF8_0000_0000_0000;
      default: z_d = {sign2_q, 63'h0};
    endcase
  end

  // stage 1 register: capture normalized fields
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q    <= 1'b0;
      sign1_q <= 1'b0;
      cls1_q  <= '0;
      e1_q    <= '0;
      mant1_q <= '0;
      g1_q    <= 1'b0;
      r1_q    <= 1'b0;
      s1_q    <= 1'b0;
    end else if (adv) begin
      v1_q    <= in_valid;
      sign1_q <= in_sign;
      cls1_q  <= in_class;
      e1_q    <= e1_d;
      mant1_q <= n_d[Q_W-2:Q_W-53];
      g1_q    <= n_d[Q_W-54];
      r1_q    <= n_d[Q_W-55];
      s1_q    <= (|n_d[Q_W-56:0]) | in_sticky;
    end
  end

  // stage 2 register: rounded mantissa and exponent
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2_q    <= 1'b0;
      sign2_q <= 1'b0;
      cls2_q  <= '0;
      e2_q    <= '0;
      mant2_q <= '0;
    end else if (adv) begin
      v2_q    <= v1_q;
      sign2_q <= sign1_q;
      cls2_q  <= cls1_q;
      e2_q    <= e2_d;
      mant2_q <= mant2_d;
    end
  end

  // stage 3 register: result word, held across bubbles and stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v3_q <= 1'b0;
      z_q  <= '0;
    end else if (adv) begin
      v3_q <= v2_q;
      if (v2_q) z_q <= z_d;
    end
  end

endmodule

// File: tb/tb_div_dp_round.sv
// tb_div_dp_round: directed checks of div_dp_round.
// Latency, rounding, range, backpressure and async reset.
module tb_div_dp_round;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [12:0] in_exp;
  logic [55:0] in_quot;
  logic        in_sticky;
  logic [1:0]  in_class;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] o_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_dp_round dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_quot   (in_quot),
    .in_sticky (in_sticky),
    .in_class  (in_class),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o_z       (o_z)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input int ex, input logic [55:0] q,
                       input logic st, input logic [1:0] c);
    in_sign   = s;
    in_exp    = 13'(ex);
    in_quot   = q;
    in_sticky = st;
    in_class  = c;
  endtask

  // one item through an idle pipe; out_valid must appear on the 3rd edge
  task automatic send(input string tag, input logic s, input int ex,
                      input logic [55:0] q, input logic st,
                      input logic [1:0] c, input logic [63:0] expz,
                      input logic chkz);
    out_ready = 1'b1;
    drive(s, ex, q, st, c);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
    step();
    chk({tag, "_lat2"}, 64'(out_valid), 64'd0);
    step();
    chk({tag, "_vld"}, 64'(out_valid), 64'd1);
    if (chkz) chk(tag, o_z, expz);
    step();
  endtask

  logic [55:0] sq [6];
  logic [63:0] sz [6];

  initial begin
    int sent;
    int got;
    int lowcnt;
    int ovcnt;
    logic seen;
    logic prev_stall;
    logic [63:0] prev_z;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 0, 56'h0, 1'b0, 2'b00);
    #12;
    chk("rst_ovalid", 64'(out_valid), 64'd0);
    chk("rst_oz", o_z, 64'h0);
    reset = 1'b0;
    step();
    chk("rst_iready", 64'(in_ready), 64'd1);

    send("one", 1'b0, 0, 56'h80_0000_0000_0000, 1'b0, 2'b00,
         64'h3FF0_0000_0000_0000, 1'b1);
    send("third", 1'b0, 0, 56'h55_5555_5555_5555, 1'b1, 2'b00,
         64'h3FE5_5555_5555_5555, 1'b1);
    send("carry", 1'b0, 0, 56'hFF_FFFF_FFFF_FFFF, 1'b1, 2'b00,
         64'h4000_0000_0000_0000, 1'b1);
    send("tie_dn", 1'b0, 0, 56'h80_0000_0000_0004, 1'b0, 2'b00,
         64'h3FF0_0000_0000_0000, 1'b1);
    send("tie_up", 1'b0, 0, 56'h80_0000_0000_000C, 1'b0, 2'b00,
         64'h3FF0_0000_0000_0002, 1'b1);
    send("ovf", 1'b0, 1024, 56'h80_0000_0000_0000, 1'b0, 2'b00,
         64'h7FF0_0000_0000_0000, 1'b1);
    send("emax", 1'b0, 1023, 56'h80_0000_0000_0000, 1'b0, 2'b00,
         64'h7FE0_0000_0000_0000, 1'b1);
    send("emin", 1'b0, -1022, 56'h80_0000_0000_0000, 1'b0, 2'b00,
         64'h0010_0000_0000_0000, 1'b1);
    send("unf", 1'b1, -1023, 56'h80_0000_0000_0000, 1'b0, 2'b00,
         64'h8000_0000_0000_0000, 1'b1);
    send("unf_norm", 1'b0, -1022, 56'h55_5555_5555_5555, 1'b0, 2'b00,
         64'h0000_0000_0000_0000, 1'b1);
    send("nan", 1'b1, 5, 56'h12_3456_789A_BCDE, 1'b1, 2'b11,
         64'h7FF8_0000_0000_0000, 1'b1);
    send("inf", 1'b1, 5, 56'h0, 1'b0, 2'b10,
         64'hFFF0_0000_0000_0000, 1'b1);
    send("zero", 1'b1, 5, 56'h0, 1'b0, 2'b01,
         64'h8000_0000_0000_0000, 1'b1);
    send("illegal", 1'b0, 0, 56'h20_0000_0000_0000, 1'b0, 2'b00,
         64'h0, 1'b0);

    sq[0] = 56'h80_0000_0000_0000; sz[0] = 64'h3FF0_0000_0000_0000;
    sq[1] = 56'h80_0000_0000_0008; sz[1] = 64'h4000_0000_0000_0001;
    sq[2] = 56'h80_0000_0000_0010; sz[2] = 64'h4010_0000_0000_0002;
    sq[3] = 56'h80_0000_0000_0018; sz[3] = 64'h4020_0000_0000_0003;
    sq[4] = 56'h80_0000_0000_0020; sz[4] = 64'h4030_0000_0000_0004;
    sq[5] = 56'h80_0000_0000_0028; sz[5] = 64'h4040_0000_0000_0005;
    sent = 0;
    got = 0;
    lowcnt = 0;
    seen = 1'b0;
    prev_stall = 1'b0;
    prev_z = '0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      if (prev_stall) begin
        chk("bp_hold_vld", 64'(out_valid), 64'd1);
        chk("bp_hold_z", o_z, prev_z);
      end
      if (out_valid) seen = 1'b1;
      out_ready = !(seen && lowcnt < 5);
      if (seen && !out_ready) lowcnt++;
      in_valid = (sent < 6);
      if (sent < 6) drive(1'b0, sent, sq[sent], 1'b0, 2'b00);
      #1;
      if (out_valid && !out_ready)
        chk("bp_iready", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        chk($sformatf("bp_item%0d", got), o_z, sz[got]);
        got++;
      end
      if (in_valid && in_ready) sent++;
      prev_stall = out_valid && !out_ready;
      prev_z = o_z;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", 64'(got), 64'd6);
    chk("bp_stalls", 64'(lowcnt), 64'd5);
    ovcnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) ovcnt++;
      step();
    end
    chk("bp_no_dup", 64'(ovcnt), 64'd0);

    drive(1'b0, 0, 56'h80_0000_0000_0000, 1'b0, 2'b00);
    in_valid = 1'b1;
    step();
    drive(1'b1, 1, 56'h80_0000_0000_0000, 1'b0, 2'b00);
    step();
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("mrst_ovalid", 64'(out_valid), 64'd0);
    chk("mrst_oz", o_z, 64'h0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    step();
    chk("mrst_iready", 64'(in_ready), 64'd1);
    ovcnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) ovcnt++;
      step();
    end
    chk("mrst_stale", 64'(ovcnt), 64'd0);
    chk("mrst_oz_end", o_z, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
